struct_check_fifo: RTL and testbench
====================================

# struct_check_fifo

Downstream consumer of the interface struct stage: accepts `{value, the_struct}` samples over a valid/ready handshake and checks `val100 == value + OFFSET_A` and `val200 == value + OFFSET_B`. Results are buffered in a small FIFO toward the next consumer, and running pass/error statistics are kept. It replaces ad-hoc per-clock `$stop` checks with a synthesizable, countable checker that tolerates back-pressure.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `OFFSET_A`, 100: expected `val100 - value`.
- `OFFSET_B`, 200: expected `val200 - value`.
- `CNT_W`, 16: width of the statistics counters.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  sample can be accepted.
- `in_value`  in  32  `value` field of the interface.
- `in_struct`  in  64  packed `struct_t` (`val100` in [63:32], `val200` in [31:0]).
- `out_valid`  out  1  FIFO head present.
- `out_ready`  in  1  consumer takes head.
- `out_value`  out  32  `value` of head entry.
- `out_ok`  out  1  check result of head entry.
- `clr_stats`  in  1  synchronous clear of all statistics.
- `pass_cnt`  out  CNT_W  passing samples accepted; saturating.
- `err_cnt`  out  CNT_W  failing samples accepted; saturating.
- `err_sticky`  out  1  set on first failure.
- `first_err_value`  out  32  `in_value` of first failing sample.

## Operation
- Accept: `in_valid && in_ready`. `in_ready = !full` (no pass-through when full, even with a same-cycle pop).
- Check at accept, combinational:
  - `ok_a = (val100 == in_value + OFFSET_A)`, `ok_b = (val200 == in_value + OFFSET_B)`.
  - All sums are modulo 2^32 (wrap, no sign extension issues).
  - `ok = ok_a && ok_b`.
- FIFO write: `{in_value, ok}` stored at the write pointer.
- FIFO read:
  - `out_valid = !empty`.
  - Pop on `out_valid && out_ready`.
  - `out_value` and `out_ok` come from the head entry.
  - Head outputs are stable while `out_valid && !out_ready`.
- Occupancy:
  - Tracked with a count of 0..DEPTH.
  - Push and pop in the same cycle (only possible when not full and not empty) leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Statistics, updated on accept:
  - `ok` increments `pass_cnt`; `!ok` increments `err_cnt`.
  - Counters hold at all-ones (2^CNT_W - 1).
  - First `!ok` accept while `err_sticky == 0` sets `err_sticky` and loads `first_err_value`. Later failures do not overwrite it.
- `clr_stats`:
  - Zeroes `pass_cnt`, `err_cnt`, `err_sticky` and `first_err_value` next edge.
  - It has priority: an accept in the same cycle is not counted and cannot set the sticky flag.
  - The FIFO contents are unaffected.
- Reset value of every output:
  - `in_ready` = 1; `out_valid` = 0.
  - `out_value` = 0, `out_ok` = 0 (head storage reset to 0).
  - `pass_cnt` = 0, `err_cnt` = 0, `err_sticky` = 0, `first_err_value` = 0.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous); in-flight entries are lost.

## Timing
- Accept-to-`out_valid` latency: 1 cycle (registered FIFO, no combinational bypass).
- Statistics reflect an accept on the edge that accepts it, so they are visible the next cycle.
- `in_ready` depends only on registered occupancy; no combinational path from `out_ready`.
- Throughput: 1 sample/cycle sustained when `out_ready` is held high.
- Reset deassertion is synchronized externally; the block leaves reset on the first edge with `rst_n` high.

## Structure
- Shared package `struct_chk_pkg`:
  - `struct_t` typedef (`integer val100, val200`, packed).
  - Default offset constants `OFFSET_A_DEF = 100`, `OFFSET_B_DEF = 200`.
  - Entry typedef `chk_entry_t {logic [31:0] value; logic ok;}`.
- One sub-module `struct_chk_fifo`: parameterized synchronous FIFO of `chk_entry_t`, providing `full`/`empty` and asynchronous active-low reset.
- The top level holds the compare logic and the statistics registers.

## Test plan
- Reset, then offer `value = 5`, `val100 = 105`, `val200 = 205` with `out_ready = 1`:
  - `out_valid` is seen one cycle later with `out_value = 5`, `out_ok = 1`.
  - `pass_cnt = 1`, `err_cnt = 0`.
- Offer `value = 7`, `val100 = 107`, `val200 = 999`, then `value = 8` with a bad `val100`:
  - `err_cnt = 2`, `err_sticky = 1`, `first_err_value = 7`, `out_ok = 0` for both entries.
- Hold `out_ready = 0` and offer 6 valid samples:
  - `in_ready` drops after 4 accepts; `pass_cnt = 4`.
  - Release `out_ready`: entries drain in order, and the remaining 2 samples are accepted afterward.
- Wrap check: `value = 32'hFFFF_FFF0`, `val100 = 32'h0000_0054`, `val200 = 32'h0000_00B8` gives `out_ok = 1`.
- Force `pass_cnt` to 2^CNT_W - 2 (`CNT_W = 4`, 14 passes), then 3 more passes: `pass_cnt` holds at 15.
- `clr_stats` in the same cycle as a failing accept:
  - Next cycle `err_cnt = 0`, `err_sticky = 0`.
  - The FIFO still delivers that entry with `out_ok = 0`.
  - Then assert `rst_n = 0` with 3 entries queued: `out_valid` goes to 0 at once.

Source files
------------

// File: rtl/struct_chk_pkg.sv
// Shared types and defaults for the struct checker.
// Holds the interface struct, the FIFO entry and a compare helper.
package struct_chk_pkg;

  typedef struct packed {
    integer val100;
    integer val200;
  } struct_t;

  localparam int OFFSET_A_DEF = 100;
  localparam int OFFSET_B_DEF = 200;

  typedef struct packed {
    logic [31:0] value;
    logic        ok;
  } chk_entry_t;

  // Modulo-2^32 offset compare: got == base + off.
  function automatic logic offs_ok(
    input logic [31:0] got,
    input logic [31:0] base,
    input logic [31:0] off
  );
    logic [31:0] sum;
    sum = base + off;
    return got == sum;
  endfunction

endpackage

// File: rtl/struct_chk_fifo.sv
// Small synchronous FIFO of check entries.
// Count-based occupancy, power-of-two depth, async active-low reset.
module struct_chk_fifo
  import struct_chk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  chk_entry_t wdata_i,
  input  logic       pop_i,
  output chk_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  chk_entry_t        mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy next state; pointers wrap by width.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/struct_check_fifo.sv
// Checks {value, struct} samples against fixed offsets.
// Buffers results in a FIFO and keeps saturating pass/error stats.
module struct_check_fifo
  import struct_chk_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int OFFSET_A = OFFSET_A_DEF,
  parameter int OFFSET_B = OFFSET_B_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic [63:0]      in_struct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_value,
  output logic             out_ok,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic [31:0]      first_err_value
);

  struct_t          s;
  logic             ok_a;
  logic             ok_b;
  logic             ok;
  logic             accept;
  logic             full;
  logic             empty;
  chk_entry_t       wdata;
  chk_entry_t       head;

  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [31:0]      first_q, first_d;

  assign s      = in_struct;
  assign ok_a   = offs_ok(s.val100, in_value, 32'(OFFSET_A));
  assign ok_b   = offs_ok(s.val200, in_value, 32'(OFFSET_B));
  assign ok     = ok_a && ok_b;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign out_value = head.value;
  assign out_ok    = head.ok;

  assign wdata.value = in_value;
  assign wdata.ok    = ok;

  struct_chk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i (wdata),
    .pop_i   (out_ready),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Stats next state; clear wins over a same-cycle accept.
  always_comb begin
    pass_d   = pass_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    first_d  = first_q;
    if (clr_stats) begin
      pass_d   = '0;
      err_d    = '0;
      sticky_d = 1'b0;
      first_d  = '0;
    end else if (accept) begin
      if (ok) begin
        if (pass_q != '1) begin
          pass_d = pass_q + CNT_W'(1);
        end
      end else begin
        if (err_q != '1) begin
          err_d = err_q + CNT_W'(1);
        end
        if (!sticky_q) begin
          sticky_d = 1'b1;
          first_d  = in_value;
        end
      end
    end
  end

  // Stats registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q   <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
      first_q  <= '0;
    end else begin
      pass_q   <= pass_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      first_q  <= first_d;
    end
  end

  assign pass_cnt        = pass_q;
  assign err_cnt         = err_q;
  assign err_sticky      = sticky_q;
  assign first_err_value = first_q;

endmodule

// File: tb/tb_struct_check_fifo.sv
// Scoreboard bench for struct_check_fifo.
// Directed cases plus randomized traffic vs a queue model.
module tb_struct_check_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_value;
  logic [63:0]      in_struct;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_value;
  logic             out_ok;
  logic             clr_stats;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sticky;
  logic [31:0]      first_err_value;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] v;
    logic        ok;
  } exp_t;

  exp_t        sbq[$];
  int          m_pass;
  int          m_err;
  logic        m_sticky;
  logic [31:0] m_first;

  bit rnd_on = 0;

  struct_check_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_value        (in_value),
    .in_struct       (in_struct),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_value       (out_value),
    .out_ok          (out_ok),
    .clr_stats       (clr_stats),
    .pass_cnt        (pass_cnt),
    .err_cnt         (err_cnt),
    .err_sticky      (err_sticky),
    .first_err_value (first_err_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_ok(input logic [31:0] v,
                                  input logic [63:0] st);
    logic [31:0] a;
    logic [31:0] b;
    a = v + 32'd100;
    b = v + 32'd200;
    return (st[63:32] == a) && (st[31:0] == b);
  endfunction

  // Monitor: compares outputs and stats, then applies this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_value", out_value, 0);
      check("rst_out_ok", out_ok, 0);
      check("rst_pass", pass_cnt, 0);
      check("rst_err", err_cnt, 0);
      check("rst_sticky", err_sticky, 0);
      check("rst_first", first_err_value, 0);
      sbq.delete();
      m_pass   = 0;
      m_err    = 0;
      m_sticky = 0;
      m_first  = 0;
    end else begin
      check("out_valid", out_valid, sbq.size() != 0);
      check("in_ready", in_ready, sbq.size() < DEPTH);
      check("pass_cnt", pass_cnt, m_pass);
      check("err_cnt", err_cnt, m_err);
      check("err_sticky", err_sticky, m_sticky);
      check("first_err", first_err_value, m_first);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("out_value", out_value, e.v);
          check("out_ok", out_ok, e.ok);
        end
      end
      if (in_valid && in_ready) begin
        e.v  = in_value;
        e.ok = ref_ok(in_value, in_struct);
        sbq.push_back(e);
      end
      if (clr_stats) begin
        m_pass   = 0;
        m_err    = 0;
        m_sticky = 0;
        m_first  = 0;
      end else if (in_valid && in_ready) begin
        if (e.ok) begin
          m_pass = (m_pass < MAXC) ? m_pass + 1 : MAXC;
        end else begin
          m_err = (m_err < MAXC) ? m_err + 1 : MAXC;
          if (!m_sticky) begin
            m_sticky = 1;
            m_first  = e.v;
          end
        end
      end
    end
  end

  // Random back-pressure while enabled.
  always @(posedge clk) begin
    if (rnd_on) begin
      #1 out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input logic [31:0] v,
                      input logic [31:0] a,
                      input logic [31:0] b);
    logic acc;
    int   n;
    in_valid  = 1'b1;
    in_value  = v;
    in_struct = {a, b};
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 1000) begin
        check("send_timeout", 1, 0);
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          mode;
    int          n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    in_struct = '0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    send(32'd5, 32'd105, 32'd205);
    idle();
    check("t1_valid", out_valid, 1);
    check("t1_value", out_value, 5);
    check("t1_ok", out_ok, 1);
    check("t1_pass", pass_cnt, 1);
    check("t1_err", err_cnt, 0);

    send(32'd7, 32'd107, 32'd999);
    send(32'd8, 32'd3, 32'd208);
    idle();
    tick(2);
    check("t2_err", err_cnt, 2);
    check("t2_sticky", err_sticky, 1);
    check("t2_first", first_err_value, 7);

    pulse_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'd20 + i, 32'd120 + i, 32'd220 + i);
    end
    check("t3_full", in_ready, 0);
    in_value  = 32'd24;
    in_struct = {32'd124, 32'd224};
    tick(3);
    check("t3_hold", in_ready, 0);
    check("t3_pass", pass_cnt, 4);
    out_ready = 1'b1;
    send(32'd24, 32'd124, 32'd224);
    send(32'd25, 32'd125, 32'd225);
    idle();
    tick(6);

    send(32'hFFFF_FFF0, 32'h0000_0054, 32'h0000_00B8);
    idle();
    check("t4_wrap_ok", out_ok, 1);
    tick(2);

    pulse_clr();
    for (int i = 0; i < 14; i++) begin
      send(i, i + 100, i + 200);
    end
    idle();
    tick(1);
    check("t5_pass14", pass_cnt, 14);
    for (int i = 0; i < 3; i++) begin
      send(i, i + 100, i + 200);
    end
    idle();
    tick(1);
    check("t5_sat", pass_cnt, 15);

    pulse_clr();
    rnd_on = 1;
    for (int i = 0; i < 300; i++) begin
      v    = $urandom;
      mode = $urandom_range(0, 3);
      clr_stats = ($urandom_range(0, 19) == 0);
      if (mode == 2) begin
        send(v, v + 32'd101, v + 32'd200);
      end else if (mode == 3) begin
        send(v, v + 32'd100, v ^ 32'h8000_0000);
      end else begin
        send(v, v + 32'd100, v + 32'd200);
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        tick($urandom_range(1, 3));
      end
    end
    clr_stats = 1'b0;
    idle();
    rnd_on = 0;
    tick(1);
    out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check("drain_empty", sbq.size(), 0);
    tick(1);

    clr_stats = 1'b1;
    send(32'd50, 32'd150, 32'd0);
    clr_stats = 1'b0;
    idle();
    check("t6_err", err_cnt, 0);
    check("t6_sticky", err_sticky, 0);
    check("t6_value", out_value, 50);
    check("t6_ok", out_ok, 0);
    tick(1);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'd60 + i, 32'd160 + i, 32'd260 + i);
    end
    idle();
    check("t7_queued", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t7_async_valid", out_valid, 0);
    check("t7_async_ready", in_ready, 1);
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
